// File: rtl/vram_write_scheduler.sv
// vram_write_scheduler
//
// Arbitrates the single write port of the 32x32 x 3-bit video memory between
// non-stallable CPU WVM writes and a rectangle-fill engine. CPU writes always
// win. The fill cursor holds for one cycle whenever a CPU write takes the port.
//
// Ports:
//   Clock, Reset        - clock; synchronous active-high reset
//   iCpuWrite/Addr/Color- single-cycle CPU write request
//   iFillStart          - start a fill (sampled only when idle)
//   iFillAbort          - abandon a running fill
//   iFillX0/Y0/X1/Y1    - inclusive rectangle corners (column, row)
//   iFillColor          - fill color
//   oWriteEnable/oWriteAddress/oDataOut - registered video memory write port
//   oFillBusy           - high while a fill is in progress
//   oFillDone           - one-cycle pulse on normal fill completion
module vram_write_scheduler #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned COLOR_W = 3
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iCpuWrite,
  input  logic [ADDR_W-1:0]  iCpuAddr,
  input  logic [COLOR_W-1:0] iCpuColor,
  input  logic               iFillStart,
  input  logic               iFillAbort,
  input  logic [4:0]         iFillX0,
  input  logic [4:0]         iFillY0,
  input  logic [4:0]         iFillX1,
  input  logic [4:0]         iFillY1,
  input  logic [COLOR_W-1:0] iFillColor,
  output logic               oWriteEnable,
  output logic [ADDR_W-1:0]  oWriteAddress,
  output logic [COLOR_W-1:0] oDataOut,
  output logic               oFillBusy,
  output logic               oFillDone
);

  localparam logic StIdle = 1'b0;
  localparam logic StFill = 1'b1;

  logic               state_q, state_d;
  logic [4:0]         x0_q, x0_d;
  logic [4:0]         x1_q, x1_d;
  logic [4:0]         y1_q, y1_d;
  logic [4:0]         cx_q, cx_d;
  logic [4:0]         cy_q, cy_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COLOR_W-1:0] data_q, data_d;
  logic               done_q, done_d;

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    color_d = color_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;

    // CPU has absolute priority on the port.
    if (iCpuWrite) begin
      we_d   = 1'b1;
      addr_d = iCpuAddr;
      data_d = iCpuColor;
    end

    case (state_q)
      StIdle: begin
        if (iFillStart) begin
          x0_d    = iFillX0;
          x1_d    = iFillX1;
          y1_d    = iFillY1;
          color_d = iFillColor;
          cx_d    = iFillX0;
          cy_d    = iFillY0;
          // Empty rectangle completes immediately without entering FILL.
          if ((iFillX0 > iFillX1) || (iFillY0 > iFillY1)) begin
            done_d = 1'b1;
          end else begin
            state_d = StFill;
          end
        end
      end
      StFill: begin
        if (iFillAbort) begin
          state_d = StIdle;
        end else if (!iCpuWrite) begin
          we_d   = 1'b1;
          addr_d = ADDR_W'({cy_q, cx_q});
          data_d = color_q;
          if (cx_q == x1_q) begin
            if (cy_q == y1_q) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              cx_d = x0_q;
              cy_d = cy_q + 5'd1;
            end
          end else begin
            cx_d = cx_q + 5'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StIdle;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      color_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      color_q <= color_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign oWriteEnable  = we_q;
  assign oWriteAddress = addr_q;
  assign oDataOut      = data_q;
  assign oFillBusy     = state_q;
  assign oFillDone     = done_q;

endmodule

// File: tb/tb_vram_write_scheduler.sv
module tb_vram_write_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_we;
  logic [9:0] cpu_addr;
  logic [2:0] cpu_color;
  logic       fill_start;
  logic       fill_abort;
  logic [4:0] fx0, fy0, fx1, fy1;
  logic [2:0] fcolor;
  logic       we;
  logic [9:0] waddr;
  logic [2:0] wdata;
  logic       busy;
  logic       done;

  int n_cmp  = 0;
  int n_fail = 0;

  vram_write_scheduler #(.ADDR_W(10), .COLOR_W(3)) dut (
    .Clock        (clk),
    .Reset        (rst),
    .iCpuWrite    (cpu_we),
    .iCpuAddr     (cpu_addr),
    .iCpuColor    (cpu_color),
    .iFillStart   (fill_start),
    .iFillAbort   (fill_abort),
    .iFillX0      (fx0),
    .iFillY0      (fy0),
    .iFillX1      (fx1),
    .iFillY1      (fy1),
    .iFillColor   (fcolor),
    .oWriteEnable (we),
    .oWriteAddress(waddr),
    .oDataOut     (wdata),
    .oFillBusy    (busy),
    .oFillDone    (done)
  );

  always #5 clk = ~clk;

  // Reference model: a fill is a list of pending pixel addresses; each free
  // port cycle pops one, CPU requests take the port first.
  int         pend[$];
  bit         m_busy;
  bit [2:0]   m_color;
  bit         e_we;
  bit [9:0]   e_addr;
  bit [2:0]   e_data;
  bit         e_done;
  bit         e_busy;

  function automatic void model_step();
    if (rst) begin
      pend.delete();
      m_busy = 0; m_color = 0;
      e_we = 0; e_addr = 0; e_data = 0; e_done = 0; e_busy = 0;
      return;
    end
    e_we   = 0;
    e_done = 0;
    if (cpu_we) begin
      e_we = 1; e_addr = cpu_addr; e_data = cpu_color;
    end
    if (!m_busy) begin
      if (fill_start) begin
        pend.delete();
        for (int y = int'(fy0); y <= int'(fy1); y++)
          for (int x = int'(fx0); x <= int'(fx1); x++)
            pend.push_back(y * 32 + x);
        m_color = fcolor;
        if (pend.size() == 0) e_done = 1;
        else m_busy = 1;
      end
    end else if (fill_abort) begin
      pend.delete();
      m_busy = 0;
    end else if (!cpu_we) begin
      e_we   = 1;
      e_addr = 10'(pend.pop_front());
      e_data = m_color;
      if (pend.size() == 0) begin
        m_busy = 0;
        e_done = 1;
      end
    end
    e_busy = m_busy;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    cpu_we = 0; cpu_addr = 0; cpu_color = 0;
    fill_start = 0; fill_abort = 0;
    fx0 = 0; fy0 = 0; fx1 = 0; fy1 = 0; fcolor = 0;
  endtask

  task automatic start_fill(input int x0, input int y0, input int x1, input int y1,
                            input int c);
    fx0 = 5'(x0); fy0 = 5'(y0); fx1 = 5'(x1); fy1 = 5'(y1); fcolor = 3'(c);
    fill_start = 1;
    tick();
    fill_start = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    tick();
    tick();
    n_cmp++;
    if ({we, waddr, wdata, busy, done} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: got we=%b addr=%h data=%b busy=%b done=%b, want all 0",
               we, waddr, wdata, busy, done);
    end
    rst = 0;
    // Reset in the middle of a fill.
    start_fill(0, 0, 31, 31, 6);
    tick(); tick(); tick();
    rst = 1;
    tick();
    n_cmp++;
    if ({we, waddr, wdata, busy, done} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_midfill: got we=%b addr=%h data=%b busy=%b done=%b, want all 0",
               we, waddr, wdata, busy, done);
    end
    tick();
    rst = 0;
    tick();
    n_cmp++;
    if ({we, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_discard: got we=%b busy=%b done=%b, want 000", we, busy, done);
    end
  endtask

  task automatic test_cpu_only();
    cpu_we = 1; cpu_addr = 10'h3FF; cpu_color = 3'b101;
    tick();
    cpu_we = 0; cpu_addr = 0; cpu_color = 0;
    n_cmp++;
    if ({we, waddr, wdata} !== {1'b1, 10'h3FF, 3'b101}) begin
      n_fail++;
      $display("FAIL cpu_write: got we=%b addr=%h data=%b, want 1 3ff 101", we, waddr, wdata);
    end
    tick();
    n_cmp++;
    if ({we, waddr, wdata, busy} !== {1'b0, 10'h3FF, 3'b101, 1'b0}) begin
      n_fail++;
      $display("FAIL cpu_hold: got we=%b addr=%h data=%b busy=%b, want 0 3ff 101 0",
               we, waddr, wdata, busy);
    end
  endtask

  task automatic test_fill_uncontended();
    int exp_a[6] = '{10'h22, 10'h23, 10'h24, 10'h42, 10'h43, 10'h44};
    start_fill(2, 1, 4, 2, 2);
    n_cmp++;
    if ({busy, we} !== 2'b10) begin
      n_fail++;
      $display("FAIL fill_start: got busy=%b we=%b, want 1 0", busy, we);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if ({we, waddr, wdata, done, busy} !== {1'b1, 10'(exp_a[i]), 3'b010, i == 5, i != 5}) begin
        n_fail++;
        $display("FAIL fill_pix%0d: got we=%b addr=%h data=%b done=%b busy=%b, want 1 %h 010 %b %b",
                 i, we, waddr, wdata, done, busy, 10'(exp_a[i]), i == 5, i != 5);
      end
    end
    tick();
    n_cmp++;
    if ({we, done, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL fill_after: got we=%b done=%b busy=%b, want 000", we, done, busy);
    end
  endtask

  task automatic test_contention();
    int exp_a[8] = '{10'h22, 10'h000, 10'h000, 10'h23, 10'h24, 10'h42, 10'h43, 10'h44};
    int exp_d[8] = '{2, 7, 7, 2, 2, 2, 2, 2};
    start_fill(2, 1, 4, 2, 2);
    for (int i = 0; i < 8; i++) begin
      cpu_we = (i == 1 || i == 2); cpu_addr = 10'h000; cpu_color = 3'b111;
      tick();
      cpu_we = 0;
      n_cmp++;
      if ({we, waddr, wdata, done} !== {1'b1, 10'(exp_a[i]), 3'(exp_d[i]), i == 7}) begin
        n_fail++;
        $display("FAIL contend%0d: got we=%b addr=%h data=%b done=%b, want 1 %h %0d %b",
                 i, we, waddr, wdata, done, 10'(exp_a[i]), exp_d[i], i == 7);
      end
    end
    tick();
    n_cmp++;
    if ({we, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL contend_end: got we=%b busy=%b, want 00", we, busy);
    end
  endtask

  task automatic test_abort();
    int seen = 0;
    start_fill(0, 0, 31, 31, 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({we, waddr, wdata} !== {1'b1, 10'(i), 3'b011}) begin
        n_fail++;
        $display("FAIL abort_pix%0d: got we=%b addr=%h data=%b, want 1 %h 011",
                 i, we, waddr, wdata, 10'(i));
      end
    end
    fill_abort = 1;
    tick();
    fill_abort = 0;
    n_cmp++;
    if ({we, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_edge: got we=%b busy=%b done=%b, want 000", we, busy, done);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (we || done) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_quiet: got %0d active cycles, want 0", seen);
    end
    start_fill(7, 3, 7, 3, 4);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_restart: got busy=%b, want 1", busy);
    end
    tick();
    n_cmp++;
    if ({we, waddr, wdata, done, busy} !== {1'b1, 10'h067, 3'b100, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_restart_pix: got we=%b addr=%h data=%b done=%b busy=%b, want 1 067 100 1 0",
               we, waddr, wdata, done, busy);
    end
  endtask

  task automatic test_degenerate();
    start_fill(5, 0, 3, 0, 1);
    n_cmp++;
    if ({we, done, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL empty_rect: got we=%b done=%b busy=%b, want 0 1 0", we, done, busy);
    end
    tick();
    n_cmp++;
    if ({we, done, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL empty_after: got we=%b done=%b busy=%b, want 000", we, done, busy);
    end
    start_fill(31, 31, 31, 31, 5);
    n_cmp++;
    if ({we, done, busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL single_start: got we=%b done=%b busy=%b, want 0 0 1", we, done, busy);
    end
    tick();
    n_cmp++;
    if ({we, waddr, wdata, done, busy} !== {1'b1, 10'h3FF, 3'b101, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL single_pix: got we=%b addr=%h data=%b done=%b busy=%b, want 1 3ff 101 1 0",
               we, waddr, wdata, done, busy);
    end
  endtask

  // Start and CPU request together on an idle edge: both accepted.
  task automatic test_start_with_cpu();
    cpu_we = 1; cpu_addr = 10'h155; cpu_color = 3'b110;
    start_fill(1, 0, 2, 0, 1);
    cpu_we = 0;
    n_cmp++;
    if ({we, waddr, wdata, busy} !== {1'b1, 10'h155, 3'b110, 1'b1}) begin
      n_fail++;
      $display("FAIL start_cpu: got we=%b addr=%h data=%b busy=%b, want 1 155 110 1",
               we, waddr, wdata, busy);
    end
    tick();
    tick();
    n_cmp++;
    if ({we, waddr, done} !== {1'b1, 10'h002, 1'b1}) begin
      n_fail++;
      $display("FAIL start_cpu_end: got we=%b addr=%h done=%b, want 1 002 1", we, waddr, done);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(999) < 2);
      cpu_we     = ($urandom_range(99) < 30);
      cpu_addr   = 10'($urandom);
      cpu_color  = 3'($urandom);
      fill_start = ($urandom_range(99) < 10);
      fill_abort = ($urandom_range(99) < 2);
      fx0 = 5'($urandom); fx1 = 5'($urandom);
      fy0 = 5'($urandom); fy1 = 5'($urandom);
      if ($urandom_range(3) != 0) fy1 = 5'(int'(fy0) + $urandom_range(2));
      fcolor = 3'($urandom);
      tick();
      n_cmp++;
      if ({we, waddr, wdata, busy, done} !== {e_we, e_addr, e_data, e_busy, e_done}) begin
        n_fail++;
        $display("FAIL random_c%0d: got we=%b addr=%h data=%b busy=%b done=%b, want %b %h %b %b %b",
                 c, we, waddr, wdata, busy, done, e_we, e_addr, e_data, e_busy, e_done);
      end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_cpu_only();
    test_fill_uncontended();
    test_contention();
    test_abort();
    test_degenerate();
    test_start_with_cpu();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
